seg_scan_mux: RTL and testbench

- Downstream of the binary-to-7-segment digit encoder.
- Consumes its four active-low 7-segment codes (units, tens, hundreds, thousands) and time-multiplexes them onto one shared segment bus with four active-low digit enables.
- Adds dead-time blanking between digits, optional leading-zero blanking, and frame-coherent input sampling, which prevents torn displays.

---
 rtl/seg_pkg.sv | 35 +++
 rtl/scan_timer.sv | 44 ++++
 rtl/seg_scan_mux.sv | 75 +++++++
 tb/tb_seg_scan_mux.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment path: active-low segment codes, digit
// indices and the digit-enable helper used by the scan multiplexer.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b0000001;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  localparam logic [1:0] DIG_U = 2'd0;
  localparam logic [1:0] DIG_D = 2'd1;
  localparam logic [1:0] DIG_C = 2'd2;
  localparam logic [1:0] DIG_M = 2'd3;

  // Active-low a..g (bit6..bit0); entry n is the code for digit n.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  // One frame of digit codes, index = digit position (DIG_U..DIG_M).
  typedef logic [3:0][6:0] seg_frame_t;

  function automatic logic [3:0] an_sel(input logic [1:0] i);
    return ~(4'b0001 << i);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Digit-slot timer: cnt walks 0..DIV-1 per slot, idx walks the four digits.
// Flags the frame start and the dead-time portion of each slot.
module scan_timer #(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       frame_start,
  output logic       in_blank,
  output logic [1:0] idx
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign frame_start = en && (idx == 2'd0) && (cnt == '0);

  // No dead time configured: avoid a constant-false unsigned compare.
  generate
    if (BLANK_CYC == 0) begin : g_noblank
      assign in_blank = 1'b0;
    end else begin : g_blank
      localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYC);
      assign in_blank = (cnt < BLANK_C);
    end
  endgenerate

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes four active-low 7-segment codes onto one segment bus with
// dead-time blanking, leading-zero suppression and frame-coherent sampling.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 500,
  parameter bit LZB       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] Uconv,
  input  logic [6:0] Dconv,
  input  logic [6:0] Cconv,
  input  logic [6:0] Mconv,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_tick
);

  logic       frame_start;
  logic       in_blank;
  logic [1:0] idx;

  scan_timer #(
    .DIV       (DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .frame_start (frame_start),
    .in_blank    (in_blank),
    .idx         (idx)
  );

  seg_frame_t snap;
  seg_frame_t snap_nxt;
  logic [3:0] sup;
  logic       show;

  // The output register reads the snapshot being loaded on a frame-start edge,
  // so with no dead time the units digit already shows the new frame's code.
  assign snap_nxt = frame_start ? {Mconv, Cconv, Dconv, Uconv} : snap;

  always_comb begin
    sup        = 4'b0000;
    sup[DIG_M] = LZB && (snap_nxt[DIG_M] == SEG_ZERO);
    sup[DIG_C] = sup[DIG_M] && (snap_nxt[DIG_C] == SEG_ZERO);
    sup[DIG_D] = sup[DIG_C] && (snap_nxt[DIG_D] == SEG_ZERO);
  end

  assign show = en && !in_blank && !sup[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      snap       <= {4{SEG_BLANK}};
      frame_tick <= 1'b0;
      seg        <= SEG_BLANK;
      an         <= AN_OFF;
    end else begin
      frame_tick <= frame_start;
      if (frame_start) snap <= snap_nxt;
      if (show) begin
        an  <= an_sel(idx);
        seg <= snap_nxt[idx];
      end else begin
        an  <= AN_OFF;
        seg <= SEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: three instances (dead time, no suppression, no dead
// time) share stimulus; per-frame expectations go through a scoreboard queue.
module tb_seg_scan_mux;
  import seg_pkg::*;

  logic clk = 1'b0;
  logic rst, en;
  logic [6:0] uc, dc, cc, mc;
  logic [6:0] seg_m, seg_n, seg_b;
  logic [3:0] an_m, an_n, an_b;
  logic       ft_m, ft_n, ft_b;

  always #5 clk = ~clk;

  seg_scan_mux #(.DIV(8), .BLANK_CYC(2), .LZB(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .Uconv(uc), .Dconv(dc), .Cconv(cc), .Mconv(mc),
    .seg(seg_m), .an(an_m), .frame_tick(ft_m));
  seg_scan_mux #(.DIV(8), .BLANK_CYC(2), .LZB(1'b0)) dut_nolzb (
    .clk(clk), .rst(rst), .en(en), .Uconv(uc), .Dconv(dc), .Cconv(cc), .Mconv(mc),
    .seg(seg_n), .an(an_n), .frame_tick(ft_n));
  seg_scan_mux #(.DIV(8), .BLANK_CYC(0), .LZB(1'b1)) dut_nb (
    .clk(clk), .rst(rst), .en(en), .Uconv(uc), .Dconv(dc), .Cconv(cc), .Mconv(mc),
    .seg(seg_b), .an(an_b), .frame_tick(ft_b));

  typedef struct {
    logic [6:0] u, d, c, m;
    logic [3:0] mask;  // digits visible with LZB=1
  } vec_t;

  typedef struct {
    logic [3:0] an_m;
    logic [6:0] seg_m;
    logic [3:0] an_n;
    logic [6:0] seg_n;
    logic [3:0] an_b;
    logic [6:0] seg_b;
    logic       ft;
  } exp_t;

  exp_t sbq[$];
  int nvec  = 0;
  int nfail = 0;

  localparam logic [35:0] ALL_DARK = {4'hf, 7'h7f, 1'b0, 4'hf, 7'h7f, 1'b0, 4'hf, 7'h7f, 1'b0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] all_outs();
    return {an_m, seg_m, ft_m, an_n, seg_n, ft_n, an_b, seg_b, ft_b};
  endfunction

  // Expected outputs k cycles after a frame tick, DIV=8.
  function automatic exp_t mk(input int k, input logic [6:0] u, d, c, m, input logic [3:0] mask);
    exp_t e;
    logic [3:0][6:0] codes;
    int s, cy;
    logic [3:0] on_an;
    codes = {m, c, d, u};
    s     = k / 8;
    cy    = k % 8;
    on_an = 4'(~(4'b0001 << s));
    e.ft    = (k == 0);
    e.an_m  = (cy >= 2 && mask[s]) ? on_an : 4'hf;
    e.seg_m = (cy >= 2 && mask[s]) ? codes[s] : 7'h7f;
    e.an_n  = (cy >= 2) ? on_an : 4'hf;
    e.seg_n = (cy >= 2) ? codes[s] : 7'h7f;
    e.an_b  = mask[s] ? on_an : 4'hf;
    e.seg_b = mask[s] ? codes[s] : 7'h7f;
    return e;
  endfunction

  // Steps at least one negedge, then waits (bounded) for frame_tick.
  task automatic wait_tick(input string name, output int n);
    n = 1;
    @(negedge clk);
    while (ft_m !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (ft_m !== 1'b1) chk({name, " timeout"}, 64'(ft_m), 64'd1);
  endtask

  // Starts at the negedge showing the tick; compares nk cycles. At chg_k the
  // inputs are switched to the new codes after that cycle's compare.
  task automatic frame_body(input string name, input logic [6:0] u, d, c, m,
                            input logic [3:0] mask, input int nk, input int chg_k,
                            input logic [6:0] nu, nd, nco, nm);
    exp_t e;
    for (int k = 0; k < nk; k++) sbq.push_back(mk(k, u, d, c, m, mask));
    for (int k = 0; k < nk; k++) begin
      if (k > 0) @(negedge clk);
      e = sbq.pop_front();
      chk($sformatf("%s k=%0d", name, k), 64'(all_outs()),
          64'({e.an_m, e.seg_m, e.ft, e.an_n, e.seg_n, e.ft, e.an_b, e.seg_b, e.ft}));
      if (k == chg_k) begin
        uc = nu; dc = nd; cc = nco; mc = nm;
      end
    end
  endtask

  task automatic set_in(input logic [6:0] u, d, c, m);
    uc = u; dc = d; cc = c; mc = m;
  endtask

  vec_t vecs[6];
  logic [6:0] n1, n2, n3, n4, n5, n6, n7, n8, z, nd_pat;
  int n;

  initial begin
    n1 = SEG_DIGIT[1]; n2 = SEG_DIGIT[2]; n3 = SEG_DIGIT[3]; n4 = SEG_DIGIT[4];
    n5 = SEG_DIGIT[5]; n6 = SEG_DIGIT[6]; n7 = SEG_DIGIT[7]; n8 = SEG_DIGIT[8];
    z = 7'b0000001;
    nd_pat = 7'b1010101;
    vecs[0] = '{u: n7, d: z, c: z, m: z, mask: 4'b0001};            // 0007
    vecs[1] = '{u: z, d: z, c: z, m: z, mask: 4'b0001};             // 0000
    vecs[2] = '{u: n7, d: z, c: n1, m: z, mask: 4'b0111};           // 0107
    vecs[3] = '{u: 7'h7f, d: nd_pat, c: z, m: z, mask: 4'b0011};    // non-digit tens
    vecs[4] = '{u: z, d: z, c: z, m: n1, mask: 4'b1111};            // 1000
    vecs[5] = '{u: n8, d: n8, c: n8, m: n8, mask: 4'b1111};         // 8888

    // Reset with 1234 on the inputs
    rst = 1'b1; en = 1'b1;
    set_in(n4, n3, n2, n1);
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", 64'(all_outs()), 64'(ALL_DARK));
    end
    rst = 1'b0;
    wait_tick("tick_after_reset", n);
    chk("tick_latency_after_reset", 64'(n), 64'd1);

    // Two frames of 1234, back to back
    frame_body("f1234a", n4, n3, n2, n1, 4'b1111, 32, -1, z, z, z, z);
    wait_tick("tick_period", n);
    chk("tick_period", 64'(n), 64'd1);
    frame_body("f1234b", n4, n3, n2, n1, 4'b1111, 32, -1, z, z, z, z);

    // Table: leading-zero patterns and pass-through codes
    for (int i = 0; i < 6; i++) begin
      set_in(vecs[i].u, vecs[i].d, vecs[i].c, vecs[i].m);
      wait_tick($sformatf("tick_vec%0d", i), n);
      frame_body($sformatf("vec%0d", i), vecs[i].u, vecs[i].d, vecs[i].c, vecs[i].m,
                 vecs[i].mask, 32, -1, z, z, z, z);
    end

    // Inputs change mid-frame (slot 2): old frame stays coherent
    set_in(n4, n3, n2, n1);
    wait_tick("tick_coh", n);
    frame_body("coh_old", n4, n3, n2, n1, 4'b1111, 32, 18, n8, n7, n6, n5);
    wait_tick("tick_coh_new", n);
    frame_body("coh_new", n8, n7, n6, n5, 4'b1111, 32, -1, z, z, z, z);

    // Enable dropped during slot 1 for 5 cycles
    wait_tick("tick_en", n);
    frame_body("en_pre", n8, n7, n6, n5, 4'b1111, 11, -1, z, z, z, z);
    en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("en_low_dark", 64'(all_outs()), 64'(ALL_DARK));
    end
    en = 1'b1;
    wait_tick("tick_en_rise", n);
    chk("tick_latency_en_rise", 64'(n), 64'd1);
    frame_body("en_restart", n8, n7, n6, n5, 4'b1111, 32, -1, z, z, z, z);

    // Reset mid-SHOW of slot 3, then restart with 1234
    wait_tick("tick_rst", n);
    frame_body("rst_pre", n8, n7, n6, n5, 4'b1111, 29, -1, z, z, z, z);
    rst = 1'b1;
    set_in(n4, n3, n2, n1);
    @(negedge clk);
    chk("midframe_reset", 64'(all_outs()), 64'(ALL_DARK));
    rst = 1'b0;
    wait_tick("tick_after_rst2", n);
    chk("tick_latency_after_rst2", 64'(n), 64'd1);
    frame_body("post_rst", n4, n3, n2, n1, 4'b1111, 32, -1, z, z, z, z);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
